// File: rtl/che_line_buffer_ctrl_if.sv
// Pixel-stream and line-buffer handshake bundle for che_line_buffer_ctrl.
// slave = the controller, master = upstream source / line buffer / consumer side.
interface che_line_buffer_ctrl_if #(
  parameter int DAT_WD = 9
);
  logic              pix_vld_i;
  logic [DAT_WD-1:0] pix_dat_i;
  logic              pix_rdy_o;
  logic              wr_buff_en_o;
  logic [DAT_WD-1:0] wr_buff_dat_o;
  logic [1:0]        wr_buff_num_o;
  logic              rd_rdy_i;
  logic              rd_buff_en_o;
  logic [1:0]        rd_buff_num_o;
  logic              line_done_o;
  logic [1:0]        buf_full_o;

  modport slave (
    input  pix_vld_i, pix_dat_i, rd_rdy_i,
    output pix_rdy_o, wr_buff_en_o, wr_buff_dat_o, wr_buff_num_o,
           rd_buff_en_o, rd_buff_num_o, line_done_o, buf_full_o
  );

  modport master (
    output pix_vld_i, pix_dat_i, rd_rdy_i,
    input  pix_rdy_o, wr_buff_en_o, wr_buff_dat_o, wr_buff_num_o,
           rd_buff_en_o, rd_buff_num_o, line_done_o, buf_full_o
  );
endinterface

// File: rtl/che_line_buffer_ctrl.sv
// Ping-pong line-buffer sequencer: steers whole lines alternately into buffer 0/1
// and pops them out to the consumer. Optional stall counter: CHE_LB_CTRL_STAT_EN.
//
// buffer state | meaning
// EMPTY        | no data, writable
// FILL         | line being written
// FULL         | complete line waiting for first pop
// DRAIN        | line being popped
module che_line_buffer_ctrl #(
  parameter int DAT_WD   = 9,
  parameter int LINE_LEN = 512,
  parameter int CNT_WD   = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
`ifdef CHE_LB_CTRL_STAT_EN
  output logic [15:0]          stall_cnt_o,
`endif
  che_line_buffer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } buf_st_e;

  localparam logic [CNT_WD-1:0] LAST_IDX = CNT_WD'(LINE_LEN - 1);

  buf_st_e           st_q [2];
  buf_st_e           st_d [2];
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [CNT_WD-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_WD-1:0] rd_cnt_q, rd_cnt_d;
  logic              line_done_q, line_done_d;

  logic pix_rdy;
  logic wr_acc;
  logic wr_last;
  logic rd_pop;
  logic rd_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      line_done_q <= 1'b0;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      line_done_q <= line_done_d;
    end
  end

  always_comb begin
    st_d[0]     = st_q[0];
    st_d[1]     = st_q[1];
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    line_done_d = 1'b0;

    pix_rdy = !st_q[wr_sel_q][1];
    wr_acc  = bus.pix_vld_i && pix_rdy;
    wr_last = wr_acc && (wr_cnt_q == LAST_IDX);
    rd_pop  = bus.rd_rdy_i && st_q[rd_sel_q][1];
    rd_last = rd_pop && (rd_cnt_q == LAST_IDX);

    // Write and read never share a buffer while both are active, so both
    // updates below can land in the same cycle without conflict.
    if (wr_acc) begin
      st_d[wr_sel_q] = wr_last ? FULL : FILL;
      if (wr_last) begin
        wr_cnt_d = '0;
        wr_sel_d = !wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (rd_pop) begin
      st_d[rd_sel_q] = rd_last ? EMPTY : DRAIN;
      if (rd_last) begin
        rd_cnt_d    = '0;
        rd_sel_d    = !rd_sel_q;
        line_done_d = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  assign bus.pix_rdy_o     = pix_rdy;
  assign bus.wr_buff_en_o  = wr_acc;
  assign bus.wr_buff_dat_o = bus.pix_dat_i;
  assign bus.wr_buff_num_o = {1'b0, wr_sel_q};
  assign bus.rd_buff_en_o  = rd_pop;
  assign bus.rd_buff_num_o = {1'b0, rd_sel_q};
  assign bus.line_done_o   = line_done_q;
  assign bus.buf_full_o    = {st_q[1][1], st_q[0][1]};

`ifdef CHE_LB_CTRL_STAT_EN
  logic [15:0] stall_cnt_q;

  // Window restarts once the consumer finishes a line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (line_done_q) begin
      stall_cnt_q <= '0;
    end else if (bus.pix_vld_i && !pix_rdy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_che_line_buffer_ctrl.sv
// Self-checking bench for che_line_buffer_ctrl with LINE_LEN=4: vector table,
// line-buffer model with pixel-order scoreboard, streaming and mid-line reset.
module tb_che_line_buffer_ctrl;

  localparam int DW = 9;
  localparam int LL = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  che_line_buffer_ctrl_if #(.DAT_WD(DW)) bus ();
`ifdef CHE_LB_CTRL_STAT_EN
  logic [15:0] stall_cnt;
`endif

  che_line_buffer_ctrl #(.DAT_WD(DW), .LINE_LEN(LL), .CNT_WD(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
`ifdef CHE_LB_CTRL_STAT_EN
    .stall_cnt_o(stall_cnt),
`endif
    .bus        (bus)
  );

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic          rr;
    logic          rdy;
    logic          wen;
    logic [1:0]    wnum;
    logic          ren;
    logic [1:0]    rnum;
    logic [1:0]    full;
    logic          done;
    logic [15:0]   stall;
  } vec_t;

  vec_t tq[$];
  int n_chk = 0;
  int n_fail = 0;

  // line-buffer model and scoreboard state
  logic [DW-1:0] mem [2][LL];
  int wptr [2];
  int rptr [2];
  int beats = 0;
  int pops = 0;
  logic done_next = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    beats = 0; pops = 0; done_next = 1'b0;
    wptr[0] = 0; wptr[1] = 0; rptr[0] = 0; rptr[1] = 0;
    exp_q.delete();
  endtask

  task automatic add(input logic vld, input int dat, input logic rr, input logic rdy,
                     input logic wen, input int wnum, input logic ren, input int rnum,
                     input int full, input logic done, input int stall);
    vec_t v;
    v.vld = vld; v.dat = DW'(dat); v.rr = rr; v.rdy = rdy; v.wen = wen;
    v.wnum = 2'(wnum); v.ren = ren; v.rnum = 2'(rnum); v.full = 2'(full);
    v.done = done; v.stall = 16'(stall);
    tq.push_back(v);
  endtask

  task automatic drive(input logic vld, input logic [DW-1:0] dat, input logic rr);
    @(negedge clk);
    bus.pix_vld_i = vld;
    bus.pix_dat_i = dat;
    bus.rd_rdy_i  = rr;
    #1;
  endtask

  // Called after drive(); acc says whether the bench expects this beat accepted.
  task automatic sb(input logic acc, input logic [DW-1:0] dat);
    logic [DW-1:0] got;
    int b;
    if (acc) exp_q.push_back(dat);
    chk("line_done", 32'(bus.line_done_o), 32'(done_next));
    if (bus.wr_buff_en_o) begin
      b = (beats / LL) % 2;
      chk("wr_num_seq", 32'(bus.wr_buff_num_o), 32'(b));
      chk("wr_dat", 32'(bus.wr_buff_dat_o), 32'(dat));
      mem[b][wptr[b]] = bus.wr_buff_dat_o;
      wptr[b] = (wptr[b] + 1) % LL;
      beats++;
    end
    if (bus.rd_buff_en_o) begin
      b = (pops / LL) % 2;
      chk("rd_num_seq", 32'(bus.rd_buff_num_o), 32'(b));
      got = mem[b][rptr[b]];
      rptr[b] = (rptr[b] + 1) % LL;
      if (exp_q.size() == 0) begin
        chk("rd_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("rd_data_order", 32'(got), 32'(exp_q.pop_front()));
      end
      done_next = ((pops % LL) == LL - 1);
      pops++;
    end else begin
      done_next = 1'b0;
    end
  endtask

  initial begin
    bus.pix_vld_i = 1'b0;
    bus.pix_dat_i = '0;
    bus.rd_rdy_i  = 1'b0;
    model_reset();

    //   vld dat rr | rdy wen wnum ren rnum full done stall
    add(0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(1, k, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 5; k <= 8; k++) add(1, k, 0, 1, 1, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++)  add(1, 9, 0, 0, 0, 0, 0, 0, 3, 0, k);
    for (int k = 0; k < 4; k++)  add(1, 9, 1, 0, 0, 0, 1, 0, 3, 0, 3 + k);
    add(1, 9, 1,   1, 1, 0, 1, 1, 2, 1, 7);
    add(1, 10, 1,  1, 1, 0, 1, 1, 2, 0, 0);
    add(1, 11, 1,  1, 1, 0, 1, 1, 2, 0, 0);
    add(1, 12, 1,  1, 1, 0, 1, 1, 2, 0, 0);
    add(0, 0, 0,   1, 0, 1, 0, 0, 1, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tq[i]) begin
      drive(tq[i].vld, tq[i].dat, tq[i].rr);
      chk($sformatf("v%0d_pix_rdy", i), 32'(bus.pix_rdy_o), 32'(tq[i].rdy));
      chk($sformatf("v%0d_wr_en", i), 32'(bus.wr_buff_en_o), 32'(tq[i].wen));
      chk($sformatf("v%0d_wr_num", i), 32'(bus.wr_buff_num_o), 32'(tq[i].wnum));
      chk($sformatf("v%0d_rd_en", i), 32'(bus.rd_buff_en_o), 32'(tq[i].ren));
      chk($sformatf("v%0d_rd_num", i), 32'(bus.rd_buff_num_o), 32'(tq[i].rnum));
      chk($sformatf("v%0d_buf_full", i), 32'(bus.buf_full_o), 32'(tq[i].full));
      chk($sformatf("v%0d_line_done", i), 32'(bus.line_done_o), 32'(tq[i].done));
`ifdef CHE_LB_CTRL_STAT_EN
      chk($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(tq[i].stall));
`endif
      sb(tq[i].vld && tq[i].rdy, tq[i].dat);
    end

    // Continuous streaming: buffer 0 holds a full line, buffer 1 is empty.
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, DW'(100 + k), 1'b1);
      chk("stream_pix_rdy", 32'(bus.pix_rdy_o), 32'd1);
      chk("stream_wr_en", 32'(bus.wr_buff_en_o), 32'd1);
      chk("stream_rd_en", 32'(bus.rd_buff_en_o), 32'd1);
      sb(1'b1, DW'(100 + k));
    end

    // Mid-line reset after two beats of a fresh line.
    drive(1'b0, '0, 1'b0);
    sb(1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, DW'(200 + k), 1'b0);
      sb(bus.pix_rdy_o === 1'b1 ? 1'b1 : 1'b0, DW'(200 + k));
    end
    @(negedge clk);
    bus.pix_vld_i = 1'b0;
    bus.rd_rdy_i  = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_pix_rdy", 32'(bus.pix_rdy_o), 32'd1);
    chk("rst_wr_en", 32'(bus.wr_buff_en_o), 32'd0);
    chk("rst_wr_num", 32'(bus.wr_buff_num_o), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_buff_en_o), 32'd0);
    chk("rst_rd_num", 32'(bus.rd_buff_num_o), 32'd0);
    chk("rst_line_done", 32'(bus.line_done_o), 32'd0);
    chk("rst_buf_full", 32'(bus.buf_full_o), 32'd0);
`ifdef CHE_LB_CTRL_STAT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int k = 0; k < LL; k++) begin
      drive(1'b1, DW'(300 + k), 1'b0);
      chk("post_rst_wr_en", 32'(bus.wr_buff_en_o), 32'd1);
      chk("post_rst_wr_num", 32'(bus.wr_buff_num_o), 32'd0);
      chk("post_rst_buf_full", 32'(bus.buf_full_o), 32'd0);
      sb(1'b1, DW'(300 + k));
    end
    drive(1'b0, '0, 1'b0);
    chk("post_rst_full_after_line", 32'(bus.buf_full_o), 32'd1);
    chk("post_rst_wr_num_next", 32'(bus.wr_buff_num_o), 32'd1);
    sb(1'b0, '0);

    // Drain that line and confirm its data and the done pulse.
    for (int k = 0; k < LL + 1; k++) begin
      drive(1'b0, '0, 1'b1);
      sb(1'b0, '0);
    end
    chk("post_rst_pops", 32'(pops), 32'(LL));
    chk("post_rst_buf_empty", 32'(bus.buf_full_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/che_line_buffer_ctrl.md
# che_line_buffer_ctrl

Sequencer for the two-line ping-pong line buffer in the CHE path. It accepts a pixel stream and steers each complete line alternately into buffer 0 and buffer 1. It tracks the fill state of each buffer and issues per-pixel read pops as the downstream consumer allows. It sits between the upstream pixel source and the line-buffer block, and drives that block's write and read enable/number ports.

## Interface
Parameters:
- DAT_WD, 9, pixel data width; matches the line-buffer data width.
- LINE_LEN, 512, pixels per line; must be ≤ line-buffer depth and ≥ 2.
- CNT_WD, 10, pixel counter width; 2^CNT_WD ≥ LINE_LEN.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- pix_vld_i  in  1  upstream pixel valid.
- pix_dat_i  in  DAT_WD  upstream pixel data.
- pix_rdy_o  out  1  upstream ready.
- wr_buff_en_o  out  1  line-buffer write enable.
- wr_buff_dat_o  out  DAT_WD  line-buffer write data.
- wr_buff_num_o  out  2  line-buffer write select (0/1 only).
- rd_rdy_i  in  1  downstream can take one pixel this cycle.
- rd_buff_en_o  out  1  line-buffer read pop.
- rd_buff_num_o  out  2  line-buffer read select (0/1 only).
- line_done_o  out  1  one-cycle pulse when the last pixel of a line is presented.
- buf_full_o  out  2  bit i set when buffer i is in state FULL or DRAIN.

## Operation
- Each buffer i has a 2-bit state register st[i]:
  - EMPTY=0, FILL=1, FULL=2, DRAIN=3.
  - Transitions: EMPTY→FILL on the first write beat; FILL→FULL on write beat LINE_LEN-1; FULL→DRAIN on the first pop; DRAIN→EMPTY on pop LINE_LEN-1.
  - If LINE_LEN-th beat equals first beat it is never the case (LINE_LEN ≥ 2).
- Write side:
  - Registers wr_sel (1 bit) and wr_cnt (CNT_WD).
  - pix_rdy_o = (st[wr_sel]==EMPTY || st[wr_sel]==FILL).
  - A beat is accepted when pix_vld_i && pix_rdy_o. Then wr_buff_en_o=1, wr_buff_num_o={1'b0,wr_sel}, and wr_buff_dat_o=pix_dat_i (pass-through in all cycles).
  - wr_cnt increments per beat. On beat LINE_LEN-1, wr_cnt←0 and wr_sel toggles.
- Read side:
  - Registers rd_sel and rd_cnt.
  - rd_buff_en_o = rd_rdy_i && st[rd_sel][1]. rd_buff_num_o={1'b0,rd_sel}.
  - rd_cnt increments per pop. On pop LINE_LEN-1, rd_cnt←0, rd_sel toggles, and line_done_o is registered high for the next cycle.
- Write and read always target different buffers whenever both are active, so no simultaneous transition can hit the same st[i]. Both state updates apply in the same cycle.
- A buffer freed by its last pop becomes writable in the next cycle; pix_rdy_o is based on the registered state.
- Values 2/3 are never driven on either num output.

## Timing
- Reset values:
  - pix_rdy_o=1, wr_buff_en_o=0, wr_buff_num_o=0, rd_buff_en_o=0, rd_buff_num_o=0, line_done_o=0, buf_full_o=0.
  - All st=EMPTY; counters=0; wr_sel=rd_sel=0.
- Reset mid-line discards all progress. The line-buffer block shares rstn, so its contents are cleared as well.
- Write and read enables are combinational from registered state and the same-cycle handshake: zero latency.
- The line buffer returns data one cycle after rd_buff_en_o. line_done_o aligns with the line buffer's vld_o for the last pixel.
- Latency from the last write beat to the earliest rd_buff_en_o is 1 cycle.
- Steady-state throughput is 1 pixel/cycle on both sides concurrently.
- Upstream stalls only when both buffers are FULL/DRAIN.

## Configuration
- CHE_LB_CTRL_STAT_EN defined:
  - Adds output stall_cnt_o [15:0], reset value 0.
  - Increments on every cycle with pix_vld_i && !pix_rdy_o.
  - Saturates at 16'hFFFF.
  - Clears on the cycle after each line_done_o.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
All scenarios use LINE_LEN=4.
- Reset release with pix_vld_i=0, rd_rdy_i=0 → pix_rdy_o=1, all enables 0, buf_full_o=2'b00.
- 4 consecutive beats with data 1..4, rd_rdy_i=0:
  - wr_buff_en_o=1 with num=0 for 4 cycles.
  - buf_full_o=2'b01 the cycle after the 4th beat.
  - Next beat goes to num=1.
- 8 beats, then pix_vld_i held high, rd_rdy_i=0:
  - buf_full_o=2'b11 and pix_rdy_o=0 from cycle 9.
  - With STAT_EN, stall_cnt_o counts 1,2,3….
- Both buffers full, then rd_rdy_i=1:
  - Pops with num 0,0,0,0,1,1,1,1.
  - line_done_o pulses the cycle after pops 4 and 8.
  - pix_rdy_o=1 the cycle after pop 4.
- Continuous streaming with pix_vld_i=1, rd_rdy_i=1 for 40 cycles → 1 write and 1 pop per cycle after fill, no stall, data order preserved.
- Assert rstn low after 2 beats of a line → outputs return to reset values; the next line writes num=0 starting at wr_cnt=0.
